game_fsm: RTL and testbench
===========================

// Module: game_fsm
// PURPOSE
//  Frame-level game sequencer fed by the per-pixel collision detector.
//  - Collects crash pulses raised during the raster scan and acts on them
//    once per frame, at frame_end_i.
//  - Runs the title / play / player-hit / game-over flow.
//  - Keeps lives and a 4-digit BCD score.
//  - Sequences the player and enemy1 explosion animations, enemy respawn
//    and bullet clear for the sprite and render blocks.
// PARAMETERS
//  LIVES          3    lives loaded on game start (1..3)
//  STAGE_FRAMES   4    frames shown per explosion animation stage (>=1)
//  EXPL_STAGES    4    explosion stages; *_frame_o counts 0..EXPL_STAGES-1
//  INVINC_FRAMES  120  invulnerable frames after the player respawns (<=255)
// PORTS
//  clk                   in   1   system clock
//  rst                   in   1   reset, synchronous, active-low
//  frame_end_i           in   1   1-cycle pulse after the last visible pixel
//  start_i               in   1   debounced start-button pulse
//  crash_me_enemy_i      in   1   player/enemy1 pixel overlap, level
//  crash_enemy_bullet_i  in   1   enemy1/bullet pixel overlap, level
//  state_o               out  2   0 IDLE, 1 PLAY, 2 ME_HIT, 3 OVER
//  lives_o               out  2   lives remaining
//  score_o               out  16  BCD score, 4 digits, [15:12] most significant
//  me_explode_o          out  1   player explosion animation active
//  me_frame_o            out  2   player explosion stage index
//  enemy1_explode_o      out  1   enemy1 explosion animation active
//  enemy1_frame_o        out  2   enemy1 explosion stage index
//  enemy1_respawn_o      out  1   1-cycle pulse: re-place enemy1
//  bullet_clear_o        out  1   1-cycle pulse: remove in-flight bullet
//  invincible_o          out  1   player ignores enemy collisions
// BEHAVIOUR
//  Reset (rst==0 at clk edge):
//   - state=IDLE, lives=0, score=0, all flags/pulses/frame indices 0.
//   - A reset mid-animation aborts it; no respawn pulse is produced.
//  Collision latching:
//   - hit_me and hit_en are sticky flags, set on any cycle their input is 1.
//   - hit_me is masked while invincible_o or me_explode_o is high.
//   - hit_en is masked while enemy1_explode_o is high.
//   - Flags clear on the frame_end_i cycle. An input high on that same cycle
//     counts for the closing frame.
//   - Outside PLAY the inputs are ignored.
//  All decisions below are taken on the frame_end_i cycle; outputs update on
//  the next edge (1-cycle latency). Pulses are high for exactly 1 cycle.
//  IDLE:  start_i -> PLAY; lives=LIVES; score=0; enemy1_respawn_o pulse.
//  PLAY:
//   - hit_en: score += 1 (BCD carry through 4 digits; 9999 saturates, no
//     wrap); enemy1_explode_o=1; enemy1_frame_o=0; bullet_clear_o pulse.
//   - hit_me: lives -= 1; me_explode_o=1; me_frame_o=0; state -> ME_HIT.
//   - Both flags in the same frame: both actions apply; the score counts.
//  Explosion stepping (player and enemy1 counters independent):
//   - A frame counter advances the stage after every STAGE_FRAMES frames.
//   - Enemy1: after the last stage, enemy1_explode_o=0 and
//     enemy1_respawn_o pulses.
//   - Player: after the last stage, me_explode_o=0 and the state changes:
//     lives==0 -> OVER; else -> PLAY with invincible_o=1 for INVINC_FRAMES
//     frames and an enemy1_respawn_o pulse.
//  ME_HIT: enemy1 keeps animating; no new collisions are latched.
//  OVER:
//   - Score and lives are held.
//   - start_i -> PLAY with the same actions as from IDLE.
//  start_i in PLAY or ME_HIT is ignored.
//  start_i and frame_end_i on the same cycle in IDLE/OVER: start wins and
//  there is no frame step.
//  If respawn requests from the enemy and player paths coincide, a single
//  enemy1_respawn_o pulse is produced.
// STRUCTURE
//  Shared game package (include file):
//   - state encodings ST_IDLE..ST_OVER
//   - EXPL_STAGES and STAGE_FRAMES defaults
//   - 4-bit BCD digit width
//  Sub-module explode_seq: one explosion sequencer with start, frame_end,
//  active, frame_idx and done_pulse.
//   - Instantiated twice, player and enemy1.
//  BCD score incrementer: inline combinational function.
// TESTING
//  1. Reset; start_i pulse -> state_o=1, lives_o=3, score_o=0, one
//     enemy1_respawn_o pulse.
//  2. crash_enemy_bullet_i high 5 cycles, then frame_end_i.
//     -> score_o=0001, bullet_clear_o pulse, enemy1_explode_o=1.
//     -> After 16 frames: explode_o=0 and one respawn pulse.
//  3. Preload score 0099, enemy hit -> 0100. Preload 9999, enemy hit -> 9999.
//  4. crash_me_enemy_i then frame_end_i.
//     -> state=2, lives=2; after 16 frames state=1, invincible_o=1.
//     -> A crash during the next 120 frames is ignored; frame 121 is honoured.
//  5. Three player hits -> lives=0, state=3 after the third explosion.
//     -> start_i -> state=1, lives=3, score=0.
//  6. Both crash inputs in one frame -> score+1 and lives-1.
//     -> rst=0 mid-explosion -> all outputs 0 next cycle, no respawn pulse.

Source files
------------

// File: rtl/game_fsm_pkg.sv
// Shared definitions for the frame-level game sequencer: state codes,
// explosion timing defaults and the BCD score incrementer.
package game_fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_ME_HIT = 2'd2,
        ST_OVER   = 2'd3
    } state_e;

    localparam int EXPL_STAGES_DEF  = 4;
    localparam int STAGE_FRAMES_DEF = 4;
    localparam int BCD_W            = 4;
    localparam int SCORE_DIGITS     = 4;
    localparam int SCORE_W          = BCD_W * SCORE_DIGITS;

    // Ripple a +1 through the BCD digits; a full 9999 stays put instead of wrapping.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] s);
        logic [SCORE_W-1:0] r;
        logic               carry;
        r     = s;
        carry = 1'b1;
        if (s != SCORE_W'(16'h9999)) begin
            for (int i = 0; i < SCORE_DIGITS; i++) begin
                if (carry) begin
                    if (r[i*BCD_W +: BCD_W] == BCD_W'(9)) begin
                        r[i*BCD_W +: BCD_W] = '0;
                    end else begin
                        r[i*BCD_W +: BCD_W] = r[i*BCD_W +: BCD_W] + BCD_W'(1);
                        carry = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_fsm_if.sv
// Frame-event inputs and game status outputs of the game sequencer.
interface game_fsm_if;
    import game_fsm_pkg::*;

    logic               frame_end_i;
    logic               start_i;
    logic               crash_me_enemy_i;
    logic               crash_enemy_bullet_i;
    logic [1:0]         state_o;
    logic [1:0]         lives_o;
    logic [SCORE_W-1:0] score_o;
    logic               me_explode_o;
    logic [1:0]         me_frame_o;
    logic               enemy1_explode_o;
    logic [1:0]         enemy1_frame_o;
    logic               enemy1_respawn_o;
    logic               bullet_clear_o;
    logic               invincible_o;

    modport master (
        output frame_end_i, start_i, crash_me_enemy_i, crash_enemy_bullet_i,
        input  state_o, lives_o, score_o, me_explode_o, me_frame_o,
               enemy1_explode_o, enemy1_frame_o, enemy1_respawn_o,
               bullet_clear_o, invincible_o
    );

    modport slave (
        input  frame_end_i, start_i, crash_me_enemy_i, crash_enemy_bullet_i,
        output state_o, lives_o, score_o, me_explode_o, me_frame_o,
               enemy1_explode_o, enemy1_frame_o, enemy1_respawn_o,
               bullet_clear_o, invincible_o
    );

endinterface

// File: rtl/game_fsm_explode_seq.sv
// One explosion animation: EXPL_STAGES stages of STAGE_FRAMES frames each,
// with a combinational done pulse on the frame that ends the last stage.
module explode_seq
    import game_fsm_pkg::*;
#(
    parameter int STAGE_FRAMES = STAGE_FRAMES_DEF,
    parameter int EXPL_STAGES  = EXPL_STAGES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       frame_end_i,
    output logic       active_o,
    output logic [1:0] frame_idx_o,
    output logic       done_o
);
    localparam int CW = (STAGE_FRAMES > 1) ? $clog2(STAGE_FRAMES) : 1;

    logic          active_q, active_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stage_end, last_stage;

    assign stage_end  = (cnt_q == CW'(STAGE_FRAMES - 1));
    assign last_stage = (idx_q == 2'(EXPL_STAGES - 1));
    assign done_o     = active_q && frame_end_i && stage_end && last_stage && !start_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            active_q <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            active_d = 1'b1;
            idx_d    = '0;
            cnt_d    = '0;
        end else if (active_q && frame_end_i) begin
            if (stage_end) begin
                cnt_d = '0;
                if (last_stage) begin
                    active_d = 1'b0;
                    idx_d    = '0;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign active_o    = active_q;
    assign frame_idx_o = idx_q;

endmodule

// File: rtl/game_fsm.sv
// Frame-level game sequencer: latches crash pulses during the scan and runs
// the title/play/hit/over flow, lives, BCD score and explosion sequencing.
module game_fsm
    import game_fsm_pkg::*;
#(
    parameter int LIVES         = 3,
    parameter int STAGE_FRAMES  = STAGE_FRAMES_DEF,
    parameter int EXPL_STAGES   = EXPL_STAGES_DEF,
    parameter int INVINC_FRAMES = 120
) (
    input  logic      clk,
    input  logic      rst,
    game_fsm_if.slave bus
);
    state_e             state_q, state_d;
    logic [1:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         inv_q, inv_d;
    logic               hit_me_q, hit_me_d;
    logic               hit_en_q, hit_en_d;
    logic               respawn_q, respawn_d;
    logic               bullet_q, bullet_d;

    logic       game_start, frame_step, in_play, invincible;
    logic       hit_me_now, hit_en_now, me_start, en_start;
    logic       me_active, en_active, me_done, en_done;
    logic [1:0] me_frame, en_frame;

    assign invincible = (inv_q != 8'd0);
    assign in_play    = (state_q == ST_PLAY);
    assign game_start = bus.start_i && (state_q == ST_IDLE || state_q == ST_OVER);
    // A start on a frame_end cycle swallows that frame's step.
    assign frame_step = bus.frame_end_i && !game_start;

    assign hit_me_now = hit_me_q ||
                        (in_play && bus.crash_me_enemy_i && !invincible && !me_active);
    assign hit_en_now = hit_en_q || (in_play && bus.crash_enemy_bullet_i && !en_active);
    assign me_start   = in_play && bus.frame_end_i && hit_me_now;
    assign en_start   = in_play && bus.frame_end_i && hit_en_now;

    explode_seq #(.STAGE_FRAMES(STAGE_FRAMES), .EXPL_STAGES(EXPL_STAGES)) u_me_expl (
        .clk        (clk),
        .rst        (rst),
        .start_i    (me_start),
        .frame_end_i(frame_step),
        .active_o   (me_active),
        .frame_idx_o(me_frame),
        .done_o     (me_done)
    );

    explode_seq #(.STAGE_FRAMES(STAGE_FRAMES), .EXPL_STAGES(EXPL_STAGES)) u_en_expl (
        .clk        (clk),
        .rst        (rst),
        .start_i    (en_start),
        .frame_end_i(frame_step),
        .active_o   (en_active),
        .frame_idx_o(en_frame),
        .done_o     (en_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            lives_q   <= '0;
            score_q   <= '0;
            inv_q     <= '0;
            hit_me_q  <= 1'b0;
            hit_en_q  <= 1'b0;
            respawn_q <= 1'b0;
            bullet_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            score_q   <= score_d;
            inv_q     <= inv_d;
            hit_me_q  <= hit_me_d;
            hit_en_q  <= hit_en_d;
            respawn_q <= respawn_d;
            bullet_q  <= bullet_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_d   = score_q;
        inv_d     = inv_q;
        hit_me_d  = bus.frame_end_i ? 1'b0 : hit_me_now;
        hit_en_d  = bus.frame_end_i ? 1'b0 : hit_en_now;
        // Enemy and player respawn requests merge into one pulse.
        respawn_d = game_start || en_done || (me_done && lives_q != 2'd0);
        bullet_d  = en_start;
        if (frame_step && invincible) begin
            inv_d = inv_q - 8'd1;
        end
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (game_start) begin
                    state_d = ST_PLAY;
                    lives_d = 2'(LIVES);
                    score_d = '0;
                    inv_d   = '0;
                end
            end
            ST_PLAY: begin
                if (en_start) begin
                    score_d = bcd_inc(score_q);
                end
                if (me_start) begin
                    lives_d = lives_q - 2'd1;
                    state_d = ST_ME_HIT;
                end
            end
            ST_ME_HIT: begin
                if (me_done) begin
                    if (lives_q == 2'd0) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_PLAY;
                        inv_d   = 8'(INVINC_FRAMES);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.state_o          = state_q;
        bus.lives_o          = lives_q;
        bus.score_o          = score_q;
        bus.me_explode_o     = me_active;
        bus.me_frame_o       = me_frame;
        bus.enemy1_explode_o = en_active;
        bus.enemy1_frame_o   = en_frame;
        bus.enemy1_respawn_o = respawn_q;
        bus.bullet_clear_o   = bullet_q;
        bus.invincible_o     = invincible;
    end

endmodule

// File: tb/tb_game_fsm.sv
// Bench for game_fsm: fixed vector table, hand-written frame sequences and
// randomized traffic against a frame-count reference model.
module tb_game_fsm;
    import game_fsm_pkg::*;

    localparam int LIVES = 3;
    localparam int SF    = 4;
    localparam int ES    = 4;
    localparam int INV   = 120;
    localparam int TOT   = SF * ES;

    logic clk = 1'b0;
    logic rst = 1'b0;
    game_fsm_if bus ();

    game_fsm #(.LIVES(LIVES), .STAGE_FRAMES(SF), .EXPL_STAGES(ES), .INVINC_FRAMES(INV)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain counters of frames remaining.
    int m_state = 0, m_lives = 0, m_score = 0;
    int m_en_left = 0, m_me_left = 0, m_inv = 0;
    bit m_fme = 0, m_fen = 0, m_resp = 0, m_bc = 0;

    typedef struct {
        bit          r, fe, st, cme, ceb;
        logic [1:0]  state, lives;
        logic [15:0] score;
        bit          en_exp, bc, resp;
    } vec_t;
    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int stage_of(input int left);
        return (left > 0) ? (TOT - left) / SF : 0;
    endfunction

    task automatic model_tick(input bit r, input bit fe, input bit st, input bit cme, input bit ceb);
        bit gs, fme_now, fen_now;
        m_resp = 0;
        m_bc   = 0;
        if (!r) begin
            m_state = 0; m_lives = 0; m_score = 0;
            m_en_left = 0; m_me_left = 0; m_inv = 0;
            m_fme = 0; m_fen = 0;
        end else begin
            gs      = (m_state == 0 || m_state == 3) && st;
            fme_now = m_fme || (m_state == 1 && cme && m_inv == 0 && m_me_left == 0);
            fen_now = m_fen || (m_state == 1 && ceb && m_en_left == 0);
            if (gs) begin
                m_state = 1; m_lives = LIVES; m_score = 0; m_inv = 0; m_resp = 1;
            end else if (fe) begin
                if (m_en_left > 0) begin
                    m_en_left--;
                    if (m_en_left == 0) m_resp = 1;
                end
                if (m_inv > 0) m_inv--;
                if (m_me_left > 0) begin
                    m_me_left--;
                    if (m_me_left == 0) begin
                        if (m_lives == 0) m_state = 3;
                        else begin m_state = 1; m_inv = INV; m_resp = 1; end
                    end
                end else if (m_state == 1) begin
                    if (fen_now) begin
                        if (m_score < 9999) m_score++;
                        m_en_left = TOT;
                        m_bc = 1;
                    end
                    if (fme_now) begin
                        m_lives--; m_me_left = TOT; m_state = 2;
                    end
                end
            end
            if (fe) begin m_fme = 0; m_fen = 0; end
            else begin m_fme = fme_now; m_fen = fen_now; end
        end
    endtask

    task automatic check_model();
        chk("m_state",   32'(bus.state_o),          32'(m_state));
        chk("m_lives",   32'(bus.lives_o),          32'(m_lives));
        chk("m_score",   32'(bus.score_o),          32'(to_bcd(m_score)));
        chk("m_me_exp",  32'(bus.me_explode_o),     32'(m_me_left > 0));
        chk("m_me_frm",  32'(bus.me_frame_o),       32'(stage_of(m_me_left)));
        chk("m_en_exp",  32'(bus.enemy1_explode_o), 32'(m_en_left > 0));
        chk("m_en_frm",  32'(bus.enemy1_frame_o),   32'(stage_of(m_en_left)));
        chk("m_respawn", 32'(bus.enemy1_respawn_o), 32'(m_resp));
        chk("m_bclear",  32'(bus.bullet_clear_o),   32'(m_bc));
        chk("m_invinc",  32'(bus.invincible_o),     32'(m_inv > 0));
    endtask

    task automatic step(input bit r, input bit fe, input bit st, input bit cme, input bit ceb);
        rst                      = r;
        bus.frame_end_i          = fe;
        bus.start_i              = st;
        bus.crash_me_enemy_i     = cme;
        bus.crash_enemy_bullet_i = ceb;
        @(posedge clk);
        model_tick(r, fe, st, cme, ceb);
        #1;
        check_model();
    endtask

    // One scan cycle carrying the crash levels, then the frame_end cycle.
    task automatic frame_pulse(input bit cme, input bit ceb);
        step(1, 0, 0, cme, ceb);
        step(1, 1, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        //             r  fe st cme ceb  state lives score     en bc resp
        vt[0]  = '{0, 0, 0, 0, 0, 2'd0, 2'd0, 16'h0000, 0, 0, 0};
        vt[1]  = '{1, 0, 0, 0, 0, 2'd0, 2'd0, 16'h0000, 0, 0, 0};
        vt[2]  = '{1, 0, 1, 0, 0, 2'd1, 2'd3, 16'h0000, 0, 0, 1};
        vt[3]  = '{1, 0, 0, 0, 0, 2'd1, 2'd3, 16'h0000, 0, 0, 0};
        vt[4]  = '{1, 0, 0, 0, 1, 2'd1, 2'd3, 16'h0000, 0, 0, 0};
        vt[5]  = '{1, 0, 0, 0, 1, 2'd1, 2'd3, 16'h0000, 0, 0, 0};
        vt[6]  = '{1, 1, 0, 0, 0, 2'd1, 2'd3, 16'h0001, 1, 1, 0};
        vt[7]  = '{1, 0, 0, 0, 1, 2'd1, 2'd3, 16'h0001, 1, 0, 0};
        vt[8]  = '{1, 1, 0, 0, 0, 2'd1, 2'd3, 16'h0001, 1, 0, 0};
        vt[9]  = '{1, 1, 0, 1, 0, 2'd2, 2'd2, 16'h0001, 1, 0, 0};
        vt[10] = '{1, 0, 1, 0, 0, 2'd2, 2'd2, 16'h0001, 1, 0, 0};
        vt[11] = '{1, 1, 0, 0, 0, 2'd2, 2'd2, 16'h0001, 1, 0, 0};

        bus.frame_end_i = 0; bus.start_i = 0;
        bus.crash_me_enemy_i = 0; bus.crash_enemy_bullet_i = 0;
        #1;

        for (int i = 0; i < 12; i++) begin
            step(vt[i].r, vt[i].fe, vt[i].st, vt[i].cme, vt[i].ceb);
            chk($sformatf("tv%0d_state", i), 32'(bus.state_o),          32'(vt[i].state));
            chk($sformatf("tv%0d_lives", i), 32'(bus.lives_o),          32'(vt[i].lives));
            chk($sformatf("tv%0d_score", i), 32'(bus.score_o),          32'(vt[i].score));
            chk($sformatf("tv%0d_enexp", i), 32'(bus.enemy1_explode_o), 32'(vt[i].en_exp));
            chk($sformatf("tv%0d_bclr", i),  32'(bus.bullet_clear_o),   32'(vt[i].bc));
            chk($sformatf("tv%0d_resp", i),  32'(bus.enemy1_respawn_o), 32'(vt[i].resp));
        end

        // Enemy has stepped 3 frames, player 1: finish both animations.
        for (int i = 1; i <= 15; i++) begin
            frame_pulse(0, 0);
            if (i == 12) chk("en_still_active", 32'(bus.enemy1_explode_o), 32'd1);
            if (i == 13) begin
                chk("en_done_exp",  32'(bus.enemy1_explode_o), 32'd0);
                chk("en_done_resp", 32'(bus.enemy1_respawn_o), 32'd1);
            end
            if (i == 15) begin
                chk("me_back_state", 32'(bus.state_o),          32'd1);
                chk("me_back_lives", 32'(bus.lives_o),          32'd2);
                chk("me_back_inv",   32'(bus.invincible_o),     32'd1);
                chk("me_back_resp",  32'(bus.enemy1_respawn_o), 32'd1);
            end
        end

        // Crashes during the invulnerable window are ignored.
        for (int f = 1; f <= INV; f++) begin
            frame_pulse(1, 0);
            chk("inv_ignore_state", 32'(bus.state_o), 32'd1);
            if (f == INV - 1) chk("inv_still", 32'(bus.invincible_o), 32'd1);
            if (f == INV)     chk("inv_over",  32'(bus.invincible_o), 32'd0);
        end
        frame_pulse(1, 0);
        chk("inv121_state", 32'(bus.state_o), 32'd2);
        chk("inv121_lives", 32'(bus.lives_o), 32'd1);

        // Last life: recover, wait out invulnerability, final hit, game over.
        repeat (TOT) frame_pulse(0, 0);
        chk("hit2_back", 32'(bus.state_o), 32'd1);
        repeat (INV) frame_pulse(0, 0);
        frame_pulse(1, 0);
        chk("hit3_state", 32'(bus.state_o), 32'd2);
        chk("hit3_lives", 32'(bus.lives_o), 32'd0);
        repeat (TOT) frame_pulse(0, 0);
        chk("over_state", 32'(bus.state_o),          32'd3);
        chk("over_resp",  32'(bus.enemy1_respawn_o), 32'd0);
        step(1, 0, 1, 0, 0);
        chk("restart_state", 32'(bus.state_o),          32'd1);
        chk("restart_lives", 32'(bus.lives_o),          32'd3);
        chk("restart_score", 32'(bus.score_o),          32'd0);
        chk("restart_resp",  32'(bus.enemy1_respawn_o), 32'd1);

        // Both crashes in one frame, then reset in the middle of the explosions.
        frame_pulse(1, 1);
        chk("both_state", 32'(bus.state_o),        32'd2);
        chk("both_lives", 32'(bus.lives_o),        32'd2);
        chk("both_score", 32'(bus.score_o),        32'h0001);
        chk("both_bclr",  32'(bus.bullet_clear_o), 32'd1);
        repeat (3) frame_pulse(0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_state", 32'(bus.state_o),          32'd0);
        chk("rst_lives", 32'(bus.lives_o),          32'd0);
        chk("rst_score", 32'(bus.score_o),          32'd0);
        chk("rst_meexp", 32'(bus.me_explode_o),     32'd0);
        chk("rst_enexp", 32'(bus.enemy1_explode_o), 32'd0);
        for (int f = 0; f < 20; f++) begin
            frame_pulse(0, 0);
            chk("rst_no_resp", 32'(bus.enemy1_respawn_o), 32'd0);
        end

        // Score carry across a digit boundary through the real datapath.
        step(1, 0, 1, 0, 0);
        for (int k = 0; k < 99; k++) begin
            frame_pulse(0, 1);
            repeat (TOT) frame_pulse(0, 0);
        end
        chk("score_0099", 32'(bus.score_o), 32'h0099);
        frame_pulse(0, 1);
        chk("score_0100", 32'(bus.score_o), 32'h0100);

        chk("bcd_9999_sat", 32'(bcd_inc(16'h9999)), 32'h9999);
        chk("bcd_0099",     32'(bcd_inc(16'h0099)), 32'h0100);
        chk("bcd_0999",     32'(bcd_inc(16'h0999)), 32'h1000);
        chk("bcd_1239",     32'(bcd_inc(16'h1239)), 32'h1240);
        chk("bcd_9998",     32'(bcd_inc(16'h9998)), 32'h9999);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(0, 299) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
